// File: rtl/differentiator.sv
// Differentiator y[n] = x[n] - x[n-LAG] over a circular history; DIFFERENTIATOR_SAT_EN clamps instead of wrapping.
// Latency: one clock from data_en to data_out/data_en_out; param_en presets the history and primes in one cycle.
// Backpressure: none, one sample per cycle sustained; param_en beats data_en, which is dropped that cycle.
module differentiator #(
    parameter int MSB = 31,
    parameter int LAG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         param_en,
    input  logic [MSB:0] param_in,
    input  logic         data_en,
    input  logic [MSB:0] data_in,
    output logic [MSB:0] data_out,
    output logic         data_en_out,
    output logic         primed
);

    localparam int PTR_W = (LAG > 1) ? $clog2(LAG) : 1;
    localparam int CNT_W = $clog2(LAG + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAG - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAG);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MSB:0]     hist_q [LAG];
    logic [MSB:0]     oldest, diff;
    logic [MSB:0]     dout_q, dout_d;
    logic             den_q, den_d;
    logic             primed_q;
    logic             hist_load, hist_wr;

    // The slot under the write pointer always holds the oldest sample.
    assign oldest  = hist_q[ptr_q];
    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

`ifdef DIFFERENTIATOR_SAT_EN
    logic [MSB+1:0] wide;
    assign wide = {data_in[MSB], data_in} - {oldest[MSB], oldest};
    always_comb begin
        diff = wide[MSB:0];
        if (wide[MSB+1] != wide[MSB]) begin
            diff = wide[MSB+1] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
    end
`else
    assign diff = data_in - oldest;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        den_d     = 1'b0;
        hist_load = 1'b0;
        hist_wr   = 1'b0;
        if (param_en) begin
            hist_load = 1'b1;
            ptr_d     = '0;
            cnt_d     = CNT_FULL;
            state_d   = S_RUN;
        end else if (data_en) begin
            hist_wr = 1'b1;
            ptr_d   = ptr_inc;
            if (state_q == S_FILL) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == CNT_FULL) begin
                    state_d = S_RUN;
                end
            end else begin
                dout_d = diff;
                den_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            ptr_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            den_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            den_q    <= den_d;
            primed_q <= (state_d == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAG; i++) hist_q[i] <= '0;
        end else if (hist_load) begin
            for (int i = 0; i < LAG; i++) hist_q[i] <= param_in;
        end else if (hist_wr) begin
            hist_q[ptr_q] <= data_in;
        end
    end

    assign data_out    = dout_q;
    assign data_en_out = den_q;
    assign primed      = primed_q;

endmodule

// File: tb/tb_differentiator.sv
// Drives four differentiator instances (LAG 1/2/3 at 32 bits, LAG 1 at 8 bits) from shared inputs.
module tb_differentiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        param_en = 1'b0;
    logic        data_en = 1'b0;
    logic [31:0] param_in = '0;
    logic [31:0] data_in = '0;

    logic [31:0] o_l1, o_l2, o_l3;
    logic [7:0]  o_b8;
    logic        e_l1, e_l2, e_l3, e_b8;
    logic        p_l1, p_l2, p_l3, p_b8;

    differentiator #(.MSB(31), .LAG(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .param_en(param_en), .param_in(param_in),
        .data_en(data_en), .data_in(data_in), .data_out(o_l1), .data_en_out(e_l1), .primed(p_l1));
    differentiator #(.MSB(31), .LAG(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .param_en(param_en), .param_in(param_in),
        .data_en(data_en), .data_in(data_in), .data_out(o_l2), .data_en_out(e_l2), .primed(p_l2));
    differentiator #(.MSB(31), .LAG(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .param_en(param_en), .param_in(param_in),
        .data_en(data_en), .data_in(data_in), .data_out(o_l3), .data_en_out(e_l3), .primed(p_l3));
    differentiator #(.MSB(7), .LAG(1)) u_b8 (
        .clk(clk), .rst_n(rst_n), .param_en(param_en), .param_in(param_in[7:0]),
        .data_en(data_en), .data_in(data_in[7:0]), .data_out(o_b8), .data_en_out(e_b8), .primed(p_b8));

    logic [31:0] dout_a [4];
    logic        den_a  [4];
    logic        pr_a   [4];
    assign dout_a[0] = o_l1;
    assign dout_a[1] = o_l2;
    assign dout_a[2] = o_l3;
    assign dout_a[3] = {24'd0, o_b8};
    assign den_a[0]  = e_l1;
    assign den_a[1]  = e_l2;
    assign den_a[2]  = e_l3;
    assign den_a[3]  = e_b8;
    assign pr_a[0]   = p_l1;
    assign pr_a[1]   = p_l2;
    assign pr_a[2]   = p_l3;
    assign pr_a[3]   = p_b8;

    // Reference model: each history is a FIFO of past samples, oldest at the front.
    int          lagv [4] = '{1, 2, 3, 1};
    logic [31:0] hq   [4][$];
    logic [31:0] exp_out [4];
    logic        exp_en  [4];
    logic        exp_pr  [4];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] ref_diff(int i, logic [31:0] x, logic [31:0] h);
        int a, b, d;
        if (i != 3) return x - h;
        a = int'($signed(x[7:0]));
        b = int'($signed(h[7:0]));
        d = a - b;
`ifdef DIFFERENTIATOR_SAT_EN
        if (d > 127)  d = 127;
        if (d < -128) d = -128;
`endif
        return {24'd0, 8'(d)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hq[i].delete();
            exp_out[i] = '0;
            exp_en[i]  = 1'b0;
            exp_pr[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic pe, input logic [31:0] pv, input logic de, input logic [31:0] dv);
        logic [31:0] x, p, old;
        for (int i = 0; i < 4; i++) begin
            x = (i == 3) ? {24'd0, dv[7:0]} : dv;
            p = (i == 3) ? {24'd0, pv[7:0]} : pv;
            exp_en[i] = 1'b0;
            if (pe) begin
                hq[i].delete();
                for (int k = 0; k < lagv[i]; k++) hq[i].push_back(p);
            end else if (de) begin
                if (hq[i].size() < lagv[i]) begin
                    hq[i].push_back(x);
                end else begin
                    old = hq[i].pop_front();
                    exp_out[i] = ref_diff(i, x, old);
                    exp_en[i]  = 1'b1;
                    hq[i].push_back(x);
                end
            end
            exp_pr[i] = (hq[i].size() == lagv[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.out%0d", tag, i), dout_a[i], exp_out[i]);
            chk($sformatf("%s.en%0d", tag, i), {31'd0, den_a[i]}, {31'd0, exp_en[i]});
            chk($sformatf("%s.primed%0d", tag, i), {31'd0, pr_a[i]}, {31'd0, exp_pr[i]});
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic pe, input logic [31:0] pv, input logic de, input logic [31:0] dv, input string tag);
        param_en = pe;
        param_in = pv;
        data_en  = de;
        data_in  = dv;
        @(posedge clk);
        model_step(pe, pv, de, dv);
        @(negedge clk);
        param_en = 1'b0;
        data_en  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(negedge clk);
        rst_n = 1'b1;
        check_all({tag, ".rel"});
    endtask

    initial begin
        int r;
        logic pe, de;
        @(negedge clk);
        do_reset("rst0");

        // Fill with LAG=1: first sample primes, second produces the difference.
        step(1'b0, 32'd0, 1'b1, 32'd5, "fill5");
        chk("fill5.l1_primed", {31'd0, p_l1}, 32'd1);
        chk("fill5.l1_en", {31'd0, e_l1}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd12, "fill12");
        chk("fill12.l1_y", o_l1, 32'd7);
        chk("fill12.l1_en", {31'd0, e_l1}, 32'd1);

        // Preset then samples on LAG=3.
        do_reset("rst1");
        step(1'b1, 32'd100, 1'b0, 32'd0, "pre100");
        chk("pre100.l3_primed", {31'd0, p_l3}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 32'd103, "s103");
        chk("s103.l3_y", o_l3, 32'd3);
        step(1'b0, 32'd0, 1'b1, 32'd110, "s110");
        chk("s110.l3_y", o_l3, 32'd10);
        step(1'b0, 32'd0, 1'b1, 32'd90, "s90");
        chk("s90.l3_y", o_l3, 32'hFFFF_FFF6);

        // Streaming with pointer wrap on LAG=3.
        do_reset("rst2");
        for (int v = 1; v <= 7; v++) begin
            step(1'b0, 32'd0, 1'b1, 32'(v), $sformatf("strm%0d", v));
            chk($sformatf("strm%0d.l3_en", v), {31'd0, e_l3}, (v > 3) ? 32'd1 : 32'd0);
            if (v > 3) chk($sformatf("strm%0d.l3_y", v), o_l3, 32'd3);
        end

        // Simultaneous param_en and data_en: preset wins, sample dropped.
        step(1'b1, 32'd50, 1'b1, 32'd9, "sim");
        chk("sim.l3_en", {31'd0, e_l3}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd60, "sim60");
        chk("sim60.l3_y", o_l3, 32'd10);

        // 8-bit overflow cases.
        step(1'b1, 32'hFFFF_FF80, 1'b0, 32'd0, "ovpre1");
        step(1'b0, 32'd0, 1'b1, 32'd127, "ov1");
`ifdef DIFFERENTIATOR_SAT_EN
        chk("ov1.b8_y", {24'd0, o_b8}, 32'h7F);
`else
        chk("ov1.b8_y", {24'd0, o_b8}, 32'hFF);
`endif
        step(1'b1, 32'd127, 1'b0, 32'd0, "ovpre2");
        step(1'b0, 32'd0, 1'b1, 32'hFFFF_FF80, "ov2");
`ifdef DIFFERENTIATOR_SAT_EN
        chk("ov2.b8_y", {24'd0, o_b8}, 32'h80);
`else
        chk("ov2.b8_y", {24'd0, o_b8}, 32'h01);
`endif

        // Mid-operation reset on LAG=2.
        do_reset("rst3");
        step(1'b0, 32'd0, 1'b1, 32'd1, "mr1");
        step(1'b0, 32'd0, 1'b1, 32'd4, "mr2");
        step(1'b0, 32'd0, 1'b1, 32'd9, "mr3");
        chk("mr3.l2_y", o_l2, 32'd8);
        do_reset("rst4");
        chk("rst4.l2_primed", {31'd0, p_l2}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd20, "mr4");
        chk("mr4.l2_en", {31'd0, e_l2}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd30, "mr5");
        chk("mr5.l2_en", {31'd0, e_l2}, 32'd0);
        chk("mr5.l2_primed", {31'd0, p_l2}, 32'd1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset("rnd_rst");
            end else begin
                pe = (r < 8);
                de = ($urandom_range(0, 3) != 0);
                step(pe, $urandom, de, $urandom, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
